// File: rtl/led_ctrl_pkg.sv
// Shared mode encoding for the slide-switch LED sequencer.
package led_ctrl_pkg;
   localparam int MODE_W = 2;

   typedef enum logic [MODE_W-1:0] {
      MODE_OFF   = 2'd0,
      MODE_ON    = 2'd1,
      MODE_BLINK = 2'd2,
      MODE_DIM   = 2'd3
   } mode_t;
endpackage

// File: rtl/switch_debounce.sv
// Two-flop synchroniser followed by a consecutive-mismatch debounce counter.
module switch_debounce #(
   parameter int DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic rstN,
   input  logic rawIn,
   output logic stableOut
);
   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

   logic             s1;
   logic             s2;
   logic [CNT_W-1:0] cnt;

   // Any matching cycle restarts the count, so only an unbroken run flips the output.
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         s1        <= 1'b0;
         s2        <= 1'b0;
         cnt       <= '0;
         stableOut <= 1'b0;
      end else begin
         s1 <= rawIn;
         s2 <= s1;
         if (s2 == stableOut) begin
            cnt <= '0;
         end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            stableOut <= s2;
            cnt       <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end
endmodule

// File: rtl/led_mode_ctrl.sv
// Slide-switch driven LED mode sequencer (OFF/ON/BLINK[/DIM]).
// Define LED_PWM_EN to include the DIM mode and its PWM counter.
module led_mode_ctrl
   import led_ctrl_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES   = 1_000_000,
   parameter int BLINK_HALF_CYCLES = 25_000_000,
   parameter int PWM_PERIOD        = 256,
   parameter int PWM_DUTY          = 32
) (
   input  logic              clk,
   input  logic              rstN,
   input  logic              slideSwitch,
   output logic              led,
   output logic [MODE_W-1:0] mode,
   output logic              switchStable
);
   localparam int BLINK_W = $clog2(BLINK_HALF_CYCLES + 1);

   mode_t              mode_q;
   mode_t              mode_next;
   logic               stable_d;
   logic               rise;
   logic               led_next;
   logic [BLINK_W-1:0] blink_cnt;
   logic               blink_off;

   switch_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_debounce (
      .clk      (clk),
      .rstN     (rstN),
      .rawIn    (slideSwitch),
      .stableOut(switchStable)
   );

   assign rise = switchStable & ~stable_d;
   assign mode = mode_q;

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         stable_d <= 1'b0;
         mode_q   <= MODE_OFF;
         led      <= 1'b0;
      end else begin
         stable_d <= switchStable;
         mode_q   <= mode_next;
         led      <= led_next;
      end
   end

   // Blink phase starts "on" because the counter and phase are parked at zero outside BLINK.
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         blink_cnt <= '0;
         blink_off <= 1'b0;
      end else if (mode_q != MODE_BLINK) begin
         blink_cnt <= '0;
         blink_off <= 1'b0;
      end else if (blink_cnt == BLINK_W'(BLINK_HALF_CYCLES - 1)) begin
         blink_cnt <= '0;
         blink_off <= ~blink_off;
      end else begin
         blink_cnt <= blink_cnt + 1'b1;
      end
   end

`ifdef LED_PWM_EN
   localparam int PWM_W = $clog2(PWM_PERIOD);

   logic [PWM_W-1:0] pwm_cnt;

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         pwm_cnt <= '0;
      end else if (mode_q != MODE_DIM) begin
         pwm_cnt <= '0;
      end else if (pwm_cnt == PWM_W'(PWM_PERIOD - 1)) begin
         pwm_cnt <= '0;
      end else begin
         pwm_cnt <= pwm_cnt + 1'b1;
      end
   end
`endif

   always_comb begin
      mode_next = mode_q;
      led_next  = 1'b0;

      if (rise) begin
         unique case (mode_q)
            MODE_OFF:   mode_next = MODE_ON;
            MODE_ON:    mode_next = MODE_BLINK;
`ifdef LED_PWM_EN
            MODE_BLINK: mode_next = MODE_DIM;
`else
            MODE_BLINK: mode_next = MODE_OFF;
`endif
            MODE_DIM:   mode_next = MODE_OFF;
            default:    mode_next = MODE_OFF;
         endcase
      end

      unique case (mode_q)
         MODE_OFF:   led_next = 1'b0;
         MODE_ON:    led_next = 1'b1;
         MODE_BLINK: led_next = ~blink_off;
`ifdef LED_PWM_EN
         MODE_DIM:   led_next = (int'(pwm_cnt) < PWM_DUTY);
`else
         MODE_DIM:   led_next = 1'b0;
`endif
         default:    led_next = 1'b0;
      endcase
   end
endmodule

// File: tb/tb_led_mode_ctrl.sv
// Directed bench for led_mode_ctrl with small timing parameters; covers both LED_PWM_EN builds.
module tb_led_mode_ctrl;
   logic       clk;
   logic       rstN;
   logic       slideSwitch;
   logic       led;
   logic [1:0] mode;
   logic       switchStable;

   int checks = 0;
   int errors = 0;

   led_mode_ctrl #(
      .DEBOUNCE_CYCLES  (4),
      .BLINK_HALF_CYCLES(3),
      .PWM_PERIOD       (8),
      .PWM_DUTY         (2)
   ) u_dut (
      .clk         (clk),
      .rstN        (rstN),
      .slideSwitch (slideSwitch),
      .led         (led),
      .mode        (mode),
      .switchStable(switchStable)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Raise the switch and wait until the mode has advanced (6 debounce + 1 FSM edge).
   task automatic press(input string tag, input logic [1:0] exp_mode);
      slideSwitch = 1'b1;
      tick(7);
      chk(tag, 32'(mode), 32'(exp_mode));
   endtask

   task automatic release_sw();
      slideSwitch = 1'b0;
      tick(8);
   endtask

   initial begin
      int blink_exp[10];
      blink_exp = '{1, 1, 1, 0, 0, 0, 1, 1, 1, 0};

      // Initial reset
      rstN        = 1'b0;
      slideSwitch = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_led", 32'(led), 32'd0);
      chk("rst_mode", 32'(mode), 32'd0);
      chk("rst_stable", 32'(switchStable), 32'd0);
      rstN = 1'b1;
      tick(2);

      // Glitch of 3 cycles must be rejected
      slideSwitch = 1'b1;
      tick(3);
      slideSwitch = 1'b0;
      tick(10);
      chk("glitch_stable", 32'(switchStable), 32'd0);
      chk("glitch_mode", 32'(mode), 32'd0);

      // Press timing: stable on 6th edge, mode on 7th, led on 8th
      slideSwitch = 1'b1;
      tick(5);
      chk("press_stable_early", 32'(switchStable), 32'd0);
      tick(1);
      chk("press_stable", 32'(switchStable), 32'd1);
      chk("press_mode_early", 32'(mode), 32'd0);
      tick(1);
      chk("press_mode", 32'(mode), 32'd1);
      chk("press_led_early", 32'(led), 32'd0);
      tick(1);
      chk("press_led", 32'(led), 32'd1);
      release_sw();
      chk("release_mode", 32'(mode), 32'd1);
      chk("release_stable", 32'(switchStable), 32'd0);
      chk("release_led", 32'(led), 32'd1);

      // BLINK pattern
      press("to_blink", 2'd2);
      for (int i = 0; i < 10; i++) begin
         tick(1);
         chk($sformatf("blink_led_%0d", i), 32'(led), 32'(blink_exp[i]));
      end
      release_sw();
      chk("blink_release_mode", 32'(mode), 32'd2);

`ifdef LED_PWM_EN
      press("to_dim", 2'd3);
      for (int i = 0; i < 16; i++) begin
         tick(1);
         chk($sformatf("dim_led_%0d", i), 32'(led), ((i % 8) < 2) ? 32'd1 : 32'd0);
      end
      release_sw();
      press("dim_wrap", 2'd0);
`else
      press("blink_wrap", 2'd0);
`endif
      tick(1);
      chk("wrap_led", 32'(led), 32'd0);
      release_sw();

      // Back to BLINK, then reset asynchronously mid-run
      press("again_on", 2'd1);
      release_sw();
      press("again_blink", 2'd2);
      tick(1);
      chk("pre_rst_led", 32'(led), 32'd1);
      tick(1);
      chk("pre_rst_cnt", 32'(u_dut.blink_cnt), 32'd2);
      rstN = 1'b0;
      #2;
      chk("async_rst_led", 32'(led), 32'd0);
      chk("async_rst_mode", 32'(mode), 32'd0);
      chk("async_rst_stable", 32'(switchStable), 32'd0);
      chk("async_rst_blink_cnt", 32'(u_dut.blink_cnt), 32'd0);
      rstN = 1'b1;

      // Switch held high through reset release counts as a fresh press
      tick(6);
      chk("held_stable", 32'(switchStable), 32'd1);
      chk("held_mode_early", 32'(mode), 32'd0);
      tick(1);
      chk("held_mode", 32'(mode), 32'd1);
      tick(1);
      chk("held_led", 32'(led), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
